// File: rtl/ascon_pack.sv
// -----------------------------------------------------------------------------
// ascon_pack
// Shared definitions for the ASCON-128 encryption control path:
//   - type_fsm_state : the states of the encryption controller
//   - ROUND_LAST     : round index at which every permutation burst ends
//   - PA_START       : round index loaded by init_a (12-round pa)
//   - PB_START       : round index loaded by init_b (6-round pb)
// -----------------------------------------------------------------------------
package ascon_pack;

    typedef enum logic [3:0] {
        IDLE,
        CONV_INIT,
        INIT_R,
        WAIT_AD,
        AD_FIRST,
        AD_R,
        WAIT_PT,
        PT_FIRST,
        PT_R,
        WAIT_FIN,
        FIN_FIRST,
        FIN_R
    } type_fsm_state;

    localparam logic [3:0] ROUND_LAST = 4'd11;
    localparam logic [3:0] PA_START   = 4'd0;
    localparam logic [3:0] PB_START   = 4'd6;

endpackage

// File: rtl/fsm_ascon_ctrl.sv
// -----------------------------------------------------------------------------
// fsm_ascon_ctrl
// Control FSM for ASCON-128 encryption. Sequences initialisation (pa), one
// associated-data block (pb), NB_PT plaintext blocks (NB_PT-1 with pb, the
// last one folded into finalisation with pa) and finalisation. It drives the
// permutation datapath enables and the external round counter, whose value
// it reads back on cpt_i.
//
// Ports:
//   clock_i           rising-edge clock
//   reset_i           asynchronous active-high reset
//   start_i           launch one encryption (sampled in IDLE only)
//   data_valid_i      AD / plaintext word valid (sampled in WAIT_* only)
//   cpt_i[3:0]        round index from the external counter
//   en_cpt_o          counter increment
//   init_a_o          counter load 0 (pa)
//   init_b_o          counter load 6 (pb)
//   data_sel_o        0: external state, 1: registered state
//   en_reg_state_o    state register load
//   en_xor_data_o     XOR data into x0 before the round
//   en_xor_key_o      XOR key into x1,x2 before the round
//   en_xor_key_end_o  XOR key into x3,x4 after the round
//   en_xor_lsb_o      XOR 1 into x4 LSB after the round
//   en_cipher_o       capture cipher register
//   cipher_valid_o    one-cycle pulse, cipher word valid (registered)
//   end_o             tag valid, sticky until the next start (registered)
//   busy_o            high in every state but IDLE
// -----------------------------------------------------------------------------
module fsm_ascon_ctrl
    import ascon_pack::*;
#(
    parameter int NB_PT = 4
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic       data_valid_i,
    input  logic [3:0] cpt_i,
    output logic       en_cpt_o,
    output logic       init_a_o,
    output logic       init_b_o,
    output logic       data_sel_o,
    output logic       en_reg_state_o,
    output logic       en_xor_data_o,
    output logic       en_xor_key_o,
    output logic       en_xor_key_end_o,
    output logic       en_xor_lsb_o,
    output logic       en_cipher_o,
    output logic       cipher_valid_o,
    output logic       end_o,
    output logic       busy_o
);

    // Plaintext blocks handled by PT_FIRST/PT_R; the last block is absorbed
    // during finalisation, so the loop exits after NB_PT-1 blocks.
    localparam logic [3:0] BLK_LAST = 4'(NB_PT - 2);

    type_fsm_state state_reg;
    type_fsm_state state_next;
    logic [3:0]    blk_reg;
    logic [3:0]    blk_next;
    logic          end_next;
    logic          round_last;

    // Every burst leaves on the same counter value; wrap-around is never used.
    assign round_last = (cpt_i == ROUND_LAST);

    // -------------------------------------------------------------------------
    // State, block counter and registered status flags
    // -------------------------------------------------------------------------
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_reg      <= IDLE;
            blk_reg        <= 4'd0;
            cipher_valid_o <= 1'b0;
            end_o          <= 1'b0;
        end else begin
            state_reg      <= state_next;
            blk_reg        <= blk_next;
            cipher_valid_o <= en_cipher_o;
            end_o          <= end_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and output decode
    // -------------------------------------------------------------------------
    always_comb begin
        state_next       = state_reg;
        blk_next         = blk_reg;
        end_next         = end_o;
        en_cpt_o         = 1'b0;
        init_a_o         = 1'b0;
        init_b_o         = 1'b0;
        data_sel_o       = 1'b0;
        en_reg_state_o   = 1'b0;
        en_xor_data_o    = 1'b0;
        en_xor_key_o     = 1'b0;
        en_xor_key_end_o = 1'b0;
        en_xor_lsb_o     = 1'b0;
        en_cipher_o      = 1'b0;
        busy_o           = (state_reg != IDLE);

        case (state_reg)
            IDLE: begin
                if (start_i) begin
                    // Counter load is masked while reset is held so every
                    // output reads 0 during reset regardless of start_i.
                    init_a_o   = !reset_i;
                    blk_next   = 4'd0;
                    end_next   = 1'b0;
                    state_next = CONV_INIT;
                end
            end

            CONV_INIT: begin
                // Round 0 runs on the external IV||K||N word.
                en_reg_state_o = 1'b1;
                en_cpt_o       = 1'b1;
                state_next     = INIT_R;
            end

            INIT_R: begin
                data_sel_o     = 1'b1;
                en_reg_state_o = 1'b1;
                if (round_last) begin
                    en_xor_key_end_o = 1'b1;
                    state_next       = WAIT_AD;
                end else begin
                    en_cpt_o = 1'b1;
                end
            end

            WAIT_AD: begin
                // Holding init_b parks the counter on the pb start value.
                init_b_o = 1'b1;
                if (data_valid_i) begin
                    state_next = AD_FIRST;
                end
            end

            AD_FIRST: begin
                data_sel_o     = 1'b1;
                en_reg_state_o = 1'b1;
                en_xor_data_o  = 1'b1;
                en_cpt_o       = 1'b1;
                state_next     = AD_R;
            end

            AD_R: begin
                data_sel_o     = 1'b1;
                en_reg_state_o = 1'b1;
                if (round_last) begin
                    // Domain separation bit after the AD permutation.
                    en_xor_lsb_o = 1'b1;
                    state_next   = WAIT_PT;
                end else begin
                    en_cpt_o = 1'b1;
                end
            end

            WAIT_PT: begin
                init_b_o = 1'b1;
                if (data_valid_i) begin
                    state_next = PT_FIRST;
                end
            end

            PT_FIRST: begin
                data_sel_o     = 1'b1;
                en_reg_state_o = 1'b1;
                en_xor_data_o  = 1'b1;
                en_cipher_o    = 1'b1;
                en_cpt_o       = 1'b1;
                state_next     = PT_R;
            end

            PT_R: begin
                data_sel_o     = 1'b1;
                en_reg_state_o = 1'b1;
                if (round_last) begin
                    if (blk_reg == BLK_LAST) begin
                        state_next = WAIT_FIN;
                    end else begin
                        blk_next   = blk_reg + 4'd1;
                        state_next = WAIT_PT;
                    end
                end else begin
                    en_cpt_o = 1'b1;
                end
            end

            WAIT_FIN: begin
                // Finalisation is a full 12-round pa: park the counter on 0.
                init_a_o = 1'b1;
                if (data_valid_i) begin
                    state_next = FIN_FIRST;
                end
            end

            FIN_FIRST: begin
                data_sel_o     = 1'b1;
                en_reg_state_o = 1'b1;
                en_xor_data_o  = 1'b1;
                en_xor_key_o   = 1'b1;
                en_cipher_o    = 1'b1;
                en_cpt_o       = 1'b1;
                state_next     = FIN_R;
            end

            FIN_R: begin
                data_sel_o     = 1'b1;
                en_reg_state_o = 1'b1;
                if (round_last) begin
                    en_xor_key_end_o = 1'b1;
                    end_next         = 1'b1;
                    state_next       = IDLE;
                end else begin
                    en_cpt_o = 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: doc/fsm_ascon_ctrl.md
Name: fsm_ascon_ctrl

Overview:
Control FSM for ASCON-128 encryption, directly upstream of permutation_finale and the round counter compteur_double_init. It sequences initialization, one associated-data block, NB_PT plaintext blocks and finalization. It does this by driving every permutation_finale enable plus the counter's en/init_a/init_b, and by reading the counter value back. It also handles the data_valid handshake and flags cipher/tag availability.

Parameters:
NB_PT, 4, number of 64-bit plaintext blocks per message (legal range 2..15)

Ports:
clock_i  in  1  system clock, rising edge
reset_i  in  1  asynchronous, active-high reset
start_i  in  1  launch encryption; sampled only in IDLE
data_valid_i  in  1  AD/plaintext word on data_i is valid; sampled only in WAIT_* states
cpt_i  in  4  round index from compteur_double_init
en_cpt_o  out  1  counter increment
init_a_o  out  1  counter load 0 (12-round pa)
init_b_o  out  1  counter load 6 (6-round pb)
data_sel_o  out  1  0: external state_i, 1: registered state
en_reg_state_o  out  1  state register load
en_xor_data_o  out  1  XOR data into x0 before round
en_xor_key_o  out  1  XOR key into x1,x2 before round
en_xor_key_end_o  out  1  XOR key into x3,x4 after round
en_xor_lsb_o  out  1  XOR 1 into x4 LSB after round
en_cipher_o  out  1  capture cipher register
cipher_valid_o  out  1  one-cycle pulse: cipher_o valid
end_o  out  1  tag_o valid, sticky
busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, active-high): state goes to IDLE, block counter to 0, every output to 0, including end_o and cipher_valid_o.
- Outputs are decoded combinationally from the state (Moore), except cipher_valid_o and end_o, which are registered.
- Outputs not listed for a state are 0.
- IDLE: on start_i, init_a_o=1, then go to CONV_INIT. end_o clears on the same edge.
- CONV_INIT: data_sel_o=0, en_reg_state_o=1, en_cpt_o=1. This is round 0 on the external IV||K||N. Next state is INIT_R.
- INIT_R: data_sel_o=1, en_reg_state_o=1, en_cpt_o=1.
  - When cpt_i==11: en_xor_key_end_o=1, en_cpt_o=0, then go to WAIT_AD.
- WAIT_AD: init_b_o=1, held so cpt stays at 6, en_reg_state_o=0. On data_valid_i, go to AD_FIRST.
- AD_FIRST: data_sel_o=1, en_reg_state_o=1, en_xor_data_o=1, en_cpt_o=1. Next state is AD_R.
- AD_R: as INIT_R.
  - When cpt_i==11: en_xor_lsb_o=1, then go to WAIT_PT.
- WAIT_PT: as WAIT_AD. On data_valid_i, go to PT_FIRST.
- PT_FIRST: as AD_FIRST, plus en_cipher_o=1. Next state is PT_R.
- PT_R: rounds as INIT_R. When cpt_i==11:
  - if blk==NB_PT-2, go to WAIT_FIN;
  - otherwise blk++ and go to WAIT_PT.
- WAIT_FIN: init_a_o=1, held so cpt stays at 0. On data_valid_i, go to FIN_FIRST.
- FIN_FIRST: data_sel_o=1, en_reg_state_o=1, en_xor_data_o=1, en_xor_key_o=1, en_cipher_o=1, en_cpt_o=1. Next state is FIN_R.
- FIN_R: as INIT_R.
  - When cpt_i==11: en_xor_key_end_o=1, then go to IDLE with end_o←1.
- Cipher pulse: cipher_valid_o=1 during the cycle after any cycle with en_cipher_o=1. This gives exactly NB_PT pulses per message.
- Round exit: the exit test in every *_R state is cpt_i==11. The FSM never relies on counter wrap-around.
- Latency with data_valid_i tied high:
  - Total: end_o rises 13+6+7·(NB_PT-1)+1+12 = 53 edges after the start-sampling edge (NB_PT=4).
  - Cipher pulses: edges +21, +28, +35, +42 relative to the same edge.
- Ignored inputs: start_i while busy_o=1; data_valid_i outside WAIT_* states.
- Reset mid-operation: abort immediately to IDLE. No tag is produced (end_o=0).
- start_i and reset deassertion in the same cycle: reset wins until deasserted; start_i is sampled on the next edge.

Decomposition:
- ascon_pack gets:
  - typedef enum logic[3:0] type_fsm_state {IDLE, CONV_INIT, INIT_R, WAIT_AD, AD_FIRST, AD_R, WAIT_PT, PT_FIRST, PT_R, WAIT_FIN, FIN_FIRST, FIN_R};
  - constants ROUND_LAST=4'd11, PA_START=4'd0, PB_START=4'd6.
- No sub-module. The round counter stays the external compteur_double_init. The block counter is a 4-bit register inside this FSM.

Test Plan:
- Reset: reset_i=1 with random inputs -> every output 0, busy_o=0. Asserting start_i at the release edge has no effect until that edge has passed.
- Full run with counter attached, data_valid_i=1: start pulse at edge E0 ->
  - en_xor_key_end_o high while cpt=11 at E12;
  - en_xor_lsb_o high at E19;
  - cipher_valid_o pulses at E21, E28, E35, E42;
  - end_o=1 from E53.
- Handshake stall: hold data_valid_i=0 for 5 cycles in WAIT_PT -> state holds, init_b_o=1, cpt_i stays 6, en_reg_state_o=0. The run then resumes, with end_o delayed by exactly 5 cycles (E58).
- Full run in a top-level bench with permutation_finale, key 000102030405060708090A0B0C0D0E0F, nonce/AD/plaintext = specification vectors -> cipher_o words and tag_o match the ASCON-128 reference vectors.
- Mid-run reset: assert reset_i during PT_R (cpt=8) -> all outputs 0 combinationally with no clock edge. A new start then produces a full 53-cycle run.
- Ignored start and end_o lifetime: start_i pulsed during INIT_R -> no effect. end_o stays 1 in IDLE until the next start_i, then clears.
